// File: rtl/rlwe_imem_load_ctrl.sv
// Boot/load sequencer: pops a length header from the host FIFO, copies the program into the
// core instruction SRAM, then releases the core and gates its fetches. Optional: RLWE_LOAD_CHECKSUM_EN.
//
// state | meaning
// HDR   | waiting for / popping the length header
// LOAD  | writing payload words into the SRAM
// CHK   | popping and comparing the trailing XOR checksum (checksum build only)
// RUN   | program loaded, core out of reset, fetches acknowledged
// ERR   | bad header or checksum, FIFO drained, waits for soft_restart
module rlwe_imem_load_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 20,
    parameter int MAX_WORDS  = 262144
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_dequeue_en,
    output logic                  mem_write_en,
    output logic [ADDR_WIDTH-1:0] mem_write_addr,
    output logic [DATA_WIDTH-1:0] mem_write_data,
    input  logic                  core_imem_req,
    input  logic [ADDR_WIDTH-1:0] core_imem_addr,
    output logic                  core_imem_ack,
    output logic                  core_rst_n,
    input  logic                  soft_restart,
    output logic                  load_done,
    output logic                  busy,
    output logic                  error,
    output logic                  fetch_fault,
    output logic [ADDR_WIDTH-2:0] word_count
);

    localparam int LW = ADDR_WIDTH - 1;
    localparam logic [LW-1:0] MAX_LEN = LW'(MAX_WORDS);
    localparam logic [LW-1:0] ONE     = LW'(1);

    typedef enum logic [2:0] {
        S_HDR,
        S_LOAD,
`ifdef RLWE_LOAD_CHECKSUM_EN
        S_CHK,
`endif
        S_RUN,
        S_ERR
    } state_t;

    state_t          state;
    logic [LW-1:0]   len;
    logic [LW-1:0]   hdr_len;
    logic            fetch_ok;
    logic            last_word;
`ifdef RLWE_LOAD_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] csum;
`endif

    assign hdr_len   = fifo_data[LW-1:0];
    assign last_word = (word_count + ONE) == len;
    // len<<2 can reach 2**ADDR_WIDTH, so the compare is one bit wider than the address
    assign fetch_ok  = {1'b0, core_imem_addr} < {len, 2'b00};

    assign fifo_dequeue_en = !fifo_empty && !soft_restart && (state != S_RUN);
    assign mem_write_en    = !fifo_empty && !soft_restart && (state == S_LOAD);
    assign mem_write_addr  = {word_count[LW-2:0], 2'b00};
    assign mem_write_data  = fifo_data;
    assign core_imem_ack   = (state == S_RUN) && core_imem_req && fetch_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_HDR;
            len         <= '0;
            word_count  <= '0;
            core_rst_n  <= 1'b0;
            load_done   <= 1'b0;
            busy        <= 1'b0;
            error       <= 1'b0;
            fetch_fault <= 1'b0;
`ifdef RLWE_LOAD_CHECKSUM_EN
            csum        <= '0;
`endif
        end else begin
            fetch_fault <= (state == S_RUN) && core_imem_req && !fetch_ok;
            if (soft_restart) begin
                state      <= S_HDR;
                len        <= '0;
                word_count <= '0;
                core_rst_n <= 1'b0;
                load_done  <= 1'b0;
                busy       <= 1'b1;
                error      <= 1'b0;
`ifdef RLWE_LOAD_CHECKSUM_EN
                csum       <= '0;
`endif
            end else begin
                case (state)
                    S_HDR: begin
                        busy <= 1'b1;
                        if (!fifo_empty) begin
                            len <= hdr_len;
`ifdef RLWE_LOAD_CHECKSUM_EN
                            csum <= fifo_data;
`endif
                            if (hdr_len == '0 || hdr_len > MAX_LEN) begin
                                state <= S_ERR;
                                error <= 1'b1;
                                busy  <= 1'b0;
                            end else begin
                                state <= S_LOAD;
                            end
                        end
                    end
                    S_LOAD: begin
                        if (!fifo_empty) begin
                            word_count <= word_count + ONE;
`ifdef RLWE_LOAD_CHECKSUM_EN
                            csum <= csum ^ fifo_data;
                            if (last_word) state <= S_CHK;
`else
                            if (last_word) begin
                                state      <= S_RUN;
                                core_rst_n <= 1'b1;
                                load_done  <= 1'b1;
                                busy       <= 1'b0;
                            end
`endif
                        end
                    end
`ifdef RLWE_LOAD_CHECKSUM_EN
                    S_CHK: begin
                        if (!fifo_empty) begin
                            busy <= 1'b0;
                            if (fifo_data == csum) begin
                                state      <= S_RUN;
                                core_rst_n <= 1'b1;
                                load_done  <= 1'b1;
                            end else begin
                                state <= S_ERR;
                                error <= 1'b1;
                            end
                        end
                    end
`endif
                    S_RUN: ;
                    S_ERR: ;
                    default: state <= S_ERR;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rlwe_imem_load_ctrl.sv
// Self-checking bench for rlwe_imem_load_ctrl: queue-based FIFO model, write log and
// a fetch range model, with randomized payloads, gaps and fetch addresses.
module tb_rlwe_imem_load_ctrl;

    localparam int DW = 32;
    localparam int AW = 20;
`ifdef RLWE_LOAD_CHECKSUM_EN
    localparam int RISE_LAG = 1;
`else
    localparam int RISE_LAG = 0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          fifo_empty = 1'b1;
    logic [DW-1:0] fifo_data = '0;
    logic          fifo_dequeue_en;
    logic          mem_write_en;
    logic [AW-1:0] mem_write_addr;
    logic [DW-1:0] mem_write_data;
    logic          core_imem_req = 1'b0;
    logic [AW-1:0] core_imem_addr = '0;
    logic          core_imem_ack;
    logic          core_rst_n;
    logic          soft_restart = 1'b0;
    logic          load_done;
    logic          busy;
    logic          error;
    logic          fetch_fault;
    logic [AW-2:0] word_count;

    always #5 clk = ~clk;

    rlwe_imem_load_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .fifo_empty(fifo_empty), .fifo_data(fifo_data), .fifo_dequeue_en(fifo_dequeue_en),
        .mem_write_en(mem_write_en), .mem_write_addr(mem_write_addr), .mem_write_data(mem_write_data),
        .core_imem_req(core_imem_req), .core_imem_addr(core_imem_addr), .core_imem_ack(core_imem_ack),
        .core_rst_n(core_rst_n), .soft_restart(soft_restart), .load_done(load_done),
        .busy(busy), .error(error), .fetch_fault(fetch_fault), .word_count(word_count)
    );

    int checks = 0;
    int failures = 0;

    logic [DW-1:0] q[$];
    logic [DW-1:0] exp_words[$];
    int            wr_addr[$];
    logic [DW-1:0] wr_data[$];
    int            gap, cyc, last_wr_cyc, rise_cyc;
    bit            rand_gaps, last_deq, last_ack;

    // One clock of the FIFO/SRAM world: drive at negedge, sample combinational outputs, pop on posedge.
    task automatic cycle();
        if (rand_gaps && gap == 0 && $urandom_range(0, 3) == 0) gap = $urandom_range(1, 3);
        fifo_empty = (q.size() == 0) || (gap > 0);
        fifo_data  = (q.size() > 0) ? q[0] : 32'hDEAD_BEEF;
        #1;
        last_deq = fifo_dequeue_en;
        last_ack = core_imem_ack;
        if (mem_write_en) begin
            wr_addr.push_back(int'(mem_write_addr));
            wr_data.push_back(mem_write_data);
            last_wr_cyc = cyc;
        end
        @(posedge clk);
        if (last_deq) void'(q.pop_front());
        if (gap > 0) gap--;
        #1;
        if (core_rst_n && rise_cyc < 0) rise_cyc = cyc;
        cyc++;
        @(negedge clk);
    endtask

    task automatic clear_logs();
        wr_addr.delete(); wr_data.delete(); exp_words.delete();
        rise_cyc = -1; last_wr_cyc = -1; gap = 0; rand_gaps = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        soft_restart = 1'b0; core_imem_req = 1'b0; core_imem_addr = '0;
        fifo_empty = 1'b1;
        q.delete();
        clear_logs();
        cyc = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Header carries random junk above the length field; checksum is XOR of header and payload.
    task automatic push_program(input int n, input logic [12:0] hi);
        logic [DW-1:0] hdr, w, x;
        hdr = {hi, 19'(n)};
        q.push_back(hdr);
        x = hdr;
        for (int i = 0; i < n; i++) begin
            w = $urandom;
            exp_words.push_back(w);
            q.push_back(w);
            x ^= w;
        end
`ifdef RLWE_LOAD_CHECKSUM_EN
        q.push_back(x);
`endif
    endtask

    task automatic run_load(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (load_done || error) begin
                ok = 1'b1;
                break;
            end
            cycle();
        end
        if (load_done || error) ok = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; fifo_empty = 1'b1; core_imem_req = 1'b1; core_imem_addr = '0;
        #3;
        checks++; if (core_rst_n !== 1'b0 || load_done !== 1'b0 || busy !== 1'b0 || error !== 1'b0) begin
            failures++; $display("FAIL reset_flags core_rst_n=%b load_done=%b busy=%b error=%b want 0000", core_rst_n, load_done, busy, error); end
        checks++; if (word_count !== '0 || fetch_fault !== 1'b0 || core_imem_ack !== 1'b0) begin
            failures++; $display("FAIL reset_misc word_count=%0d fetch_fault=%b ack=%b want 0 0 0", word_count, fetch_fault, core_imem_ack); end
        checks++; if (fifo_dequeue_en !== 1'b0 || mem_write_en !== 1'b0) begin
            failures++; $display("FAIL reset_strobes deq=%b wr=%b want 0 0", fifo_dequeue_en, mem_write_en); end
        do_reset();
        cycle();
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL busy_in_hdr got=%b want 1", busy); end
    endtask

    task automatic check_writes(input string name, input int n);
        checks++; if (wr_addr.size() != n) begin
            failures++; $display("FAIL %s_write_count got=%0d want %0d", name, wr_addr.size(), n);
        end else begin
            for (int i = 0; i < n; i++) begin
                checks++; if (wr_addr[i] != 4 * i || wr_data[i] !== exp_words[i]) begin
                    failures++;
                    $display("FAIL %s_write%0d got addr=%0h data=%h want addr=%0h data=%h", name, i, wr_addr[i], wr_data[i], 4 * i, exp_words[i]);
                end
            end
        end
    endtask

    task automatic test_basic();
        bit ok;
        do_reset();
        push_program(3, 13'h0);
        run_load(40, ok);
        checks++; if (!ok || load_done !== 1'b1 || error !== 1'b0) begin
            failures++; $display("FAIL basic_done ok=%0d load_done=%b error=%b want 1 1 0", ok, load_done, error); end
        check_writes("basic", 3);
        checks++; if (rise_cyc != last_wr_cyc + 1 + RISE_LAG - 1) begin
            failures++; $display("FAIL basic_core_rst_timing rise_cycle=%0d want %0d", rise_cyc, last_wr_cyc + RISE_LAG); end
        checks++; if (word_count !== 19'd3 || busy !== 1'b0) begin
            failures++; $display("FAIL basic_final word_count=%0d busy=%b want 3 0", word_count, busy); end
    endtask

    task automatic test_gap();
        bit ok;
        int tries;
        logic [DW-1:0] tail[$];
        do_reset();
        push_program(4, 13'h1A5);
        while (q.size() > 3) tail.push_front(q.pop_back());
        tries = 0;
        while (word_count != 19'd2 && tries < 10) begin cycle(); tries++; end
        checks++; if (word_count !== 19'd2) begin failures++; $display("FAIL gap_reach_two word_count=%0d want 2", word_count); end
        for (int i = 0; i < 5; i++) begin
            cycle();
            checks++; if (word_count !== 19'd2 || wr_addr.size() != 2) begin
                failures++; $display("FAIL gap_hold%0d word_count=%0d writes=%0d want 2 2", i, word_count, wr_addr.size()); end
        end
        foreach (tail[i]) q.push_back(tail[i]);
        run_load(40, ok);
        checks++; if (!ok || load_done !== 1'b1) begin failures++; $display("FAIL gap_done load_done=%b want 1", load_done); end
        check_writes("gap", 4);
    endtask

    task automatic test_fetch();
        bit ok, exp_ack, req;
        int addr;
        do_reset();
        push_program(3, 13'h0);
        run_load(40, ok);
        q.push_back(32'hCAFE_0001);
        core_imem_req = 1'b1; core_imem_addr = 20'h8;
        cycle();
        checks++; if (last_ack !== 1'b1 || fetch_fault !== 1'b0) begin
            failures++; $display("FAIL fetch_in_range ack=%b fault=%b want 1 0", last_ack, fetch_fault); end
        core_imem_addr = 20'hC;
        cycle();
        checks++; if (last_ack !== 1'b0 || fetch_fault !== 1'b1) begin
            failures++; $display("FAIL fetch_boundary ack=%b fault=%b want 0 1", last_ack, fetch_fault); end
        core_imem_req = 1'b0;
        cycle();
        checks++; if (fetch_fault !== 1'b0) begin failures++; $display("FAIL fetch_fault_pulse fault=%b want 0", fetch_fault); end
        for (int i = 0; i < 20; i++) begin
            req  = 1'($urandom_range(0, 1));
            addr = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, (1 << AW) - 1)) : int'($urandom_range(0, 31));
            core_imem_req = req; core_imem_addr = AW'(addr);
            exp_ack = req && (addr < 4 * 3);
            cycle();
            checks++; if (last_ack !== exp_ack || fetch_fault !== (req && !exp_ack)) begin
                failures++; $display("FAIL fetch_rand%0d addr=%0h req=%0d ack=%b fault=%b want %b %b", i, addr, req, last_ack, fetch_fault, exp_ack, req && !exp_ack); end
        end
        core_imem_req = 1'b0;
        checks++; if (q.size() != 1 || wr_addr.size() != 3) begin
            failures++; $display("FAIL run_no_pop fifo_left=%0d writes=%0d want 1 3", q.size(), wr_addr.size()); end
    endtask

    task automatic test_err();
        bit ok;
        do_reset();
        q.push_back(32'h0); q.push_back(32'h1111); q.push_back(32'h2222); q.push_back(32'h3333);
        run_load(10, ok);
        repeat (4) cycle();
        checks++; if (error !== 1'b1 || core_rst_n !== 1'b0 || load_done !== 1'b0 || busy !== 1'b0) begin
            failures++; $display("FAIL err_zero_len error=%b core_rst_n=%b load_done=%b busy=%b want 1 0 0 0", error, core_rst_n, load_done, busy); end
        checks++; if (q.size() != 0 || wr_addr.size() != 0) begin
            failures++; $display("FAIL err_drain fifo_left=%0d writes=%0d want 0 0", q.size(), wr_addr.size()); end
        push_program(1, 13'h0);
        soft_restart = 1'b1;
        cycle();
        soft_restart = 1'b0;
        checks++; if (last_deq !== 1'b0 || error !== 1'b0 || busy !== 1'b1) begin
            failures++; $display("FAIL err_restart deq=%b error=%b busy=%b want 0 0 1", last_deq, error, busy); end
        run_load(20, ok);
        checks++; if (load_done !== 1'b1 || error !== 1'b0) begin
            failures++; $display("FAIL err_reload load_done=%b error=%b want 1 0", load_done, error); end
        check_writes("err_reload", 1);
        do_reset();
        q.push_back(32'h0004_0001);
        q.push_back(32'h5555);
        run_load(10, ok);
        checks++; if (error !== 1'b1 || wr_addr.size() != 0) begin
            failures++; $display("FAIL err_oversize error=%b writes=%0d want 1 0", error, wr_addr.size()); end
    endtask

    task automatic test_restart();
        bit ok;
        int tries, qs;
        do_reset();
        push_program(5, 13'h7);
        tries = 0;
        while (word_count != 19'd2 && tries < 10) begin cycle(); tries++; end
        qs = q.size();
        soft_restart = 1'b1;
        cycle();
        soft_restart = 1'b0;
        checks++; if (last_deq !== 1'b0 || q.size() != qs) begin
            failures++; $display("FAIL restart_no_pop deq=%b fifo_left=%0d want 0 %0d", last_deq, q.size(), qs); end
        checks++; if (word_count !== '0 || core_rst_n !== 1'b0 || load_done !== 1'b0) begin
            failures++; $display("FAIL restart_state word_count=%0d core_rst_n=%b load_done=%b want 0 0 0", word_count, core_rst_n, load_done); end
        q.delete();
        clear_logs();
        push_program(1, 13'h0);
        run_load(20, ok);
        checks++; if (load_done !== 1'b1 || core_rst_n !== 1'b1 || word_count !== 19'd1) begin
            failures++; $display("FAIL restart_reload load_done=%b core_rst_n=%b word_count=%0d want 1 1 1", load_done, core_rst_n, word_count); end
        check_writes("restart_reload", 1);
    endtask

    task automatic test_random();
        bit ok;
        int n;
        for (int it = 0; it < 6; it++) begin
            do_reset();
            rand_gaps = 1'b1;
            n = $urandom_range(1, 12);
            push_program(n, 13'($urandom));
            run_load(300, ok);
            rand_gaps = 1'b0;
            checks++; if (!ok || load_done !== 1'b1 || word_count !== 19'(n)) begin
                failures++; $display("FAIL random%0d_done len=%0d load_done=%b word_count=%0d", it, n, load_done, word_count); end
            check_writes("random", n);
            checks++; if (rise_cyc < last_wr_cyc + RISE_LAG || (RISE_LAG == 0 && rise_cyc != last_wr_cyc)) begin
                failures++; $display("FAIL random%0d_rise rise_cycle=%0d last_write_cycle=%0d", it, rise_cyc, last_wr_cyc); end
        end
    endtask

`ifdef RLWE_LOAD_CHECKSUM_EN
    task automatic test_checksum();
        bit ok;
        do_reset();
        q.push_back(32'h2); q.push_back(32'h11); q.push_back(32'h22); q.push_back(32'h31);
        run_load(20, ok);
        checks++; if (load_done !== 1'b1 || error !== 1'b0 || core_rst_n !== 1'b1) begin
            failures++; $display("FAIL chk_match load_done=%b error=%b core_rst_n=%b want 1 0 1", load_done, error, core_rst_n); end
        do_reset();
        q.push_back(32'h2); q.push_back(32'h11); q.push_back(32'h22); q.push_back(32'h30);
        run_load(20, ok);
        checks++; if (error !== 1'b1 || core_rst_n !== 1'b0 || load_done !== 1'b0) begin
            failures++; $display("FAIL chk_mismatch error=%b core_rst_n=%b load_done=%b want 1 0 0", error, core_rst_n, load_done); end
    endtask
`endif

    initial begin
        @(negedge clk);
        test_reset();
        test_basic();
        test_gap();
        test_fetch();
        test_err();
        test_restart();
        test_random();
`ifdef RLWE_LOAD_CHECKSUM_EN
        test_checksum();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
